// File: rtl/frame_header_gen_if.sv
// frame_header_gen_if: beat stream from the frame-header generator to the
// downstream bit writer.
//   output_enable  beat valid (master -> slave)
//   val            field value, right-aligned (master -> slave)
//   size_of_bit    number of valid bits in val (master -> slave)
//   flush_bit      byte-flush request (master -> slave)
//   out_ready      bit writer accepts the current beat (slave -> master)
// VAL_W must match the VAL_W of the frame_header_gen instance using it.
interface frame_header_gen_if #(
    parameter int VAL_W = 64
);
    logic             output_enable;
    logic [VAL_W-1:0] val;
    logic [VAL_W-1:0] size_of_bit;
    logic             flush_bit;
    logic             out_ready;

    modport master (
        output output_enable, val, size_of_bit, flush_bit,
        input  out_ready
    );

    modport slave (
        input  output_enable, val, size_of_bit, flush_bit,
        output out_ready
    );
endinterface

// File: rtl/frame_header_gen.sv
// frame_header_gen: start-triggered ProRes frame-header generator with
// backpressure. One accepted start emits 23 fixed header fields, then the
// optional luma and chroma quant matrices (QM_PER_BEAT entries per beat,
// earliest entry in the MSBs), as {val, size_of_bit} beats.
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   start                   header request, accepted only in idle
//   horizontal..alpha_channel_type, load_luma, load_chroma
//                           frame configuration, latched at start
//   Y_QMAT, C_QMAT          quant matrices, read live, stable while busy
//   bus (master)            output_enable/val/size_of_bit/flush_bit/out_ready
//   busy                    header in progress
//   done                    one-cycle pulse after the last beat is accepted
// Build option: FRAME_HEADER_FLUSH_EN appends a zero-length flush beat
// (flush_bit=1) after the last header beat.
module frame_header_gen #(
    parameter int          VAL_W         = 64,
    parameter int          QM_ENTRY_BITS = 8,
    parameter int          QM_PER_BEAT   = 1,
    parameter logic [31:0] ENCODER_ID    = 32'h4c617663
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [15:0]         horizontal,
    input  logic [15:0]         vertical,
    input  logic [1:0]          chroma_format,
    input  logic [1:0]          interlace_mode,
    input  logic [3:0]          aspect_ratio_information,
    input  logic [3:0]          frame_rate_code,
    input  logic [7:0]          color_primaries,
    input  logic [7:0]          transfer_characteristic,
    input  logic [7:0]          matrix_coefficients,
    input  logic [3:0]          alpha_channel_type,
    input  logic                load_luma,
    input  logic                load_chroma,
    input  logic [31:0]         Y_QMAT [8][8],
    input  logic [31:0]         C_QMAT [8][8],
    frame_header_gen_if.master  bus,
    output logic                busy,
    output logic                done
);
    localparam int QM_BEATS = 64 / QM_PER_BEAT;
    localparam int QM_BITS  = QM_PER_BEAT * QM_ENTRY_BITS;
    localparam logic [5:0] FIELD_LAST = 6'd22;
    localparam logic [5:0] QM_LAST    = 6'(QM_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIELDS,
        S_LUMA_QM,
        S_CHROMA_QM
`ifdef FRAME_HEADER_FLUSH_EN
        , S_FLUSH
`endif
    } state_t;

    typedef struct packed {
        logic [15:0] horizontal;
        logic [15:0] vertical;
        logic [1:0]  chroma_format;
        logic [1:0]  interlace_mode;
        logic [3:0]  aspect;
        logic [3:0]  frame_rate;
        logic [7:0]  primaries;
        logic [7:0]  transfer;
        logic [7:0]  matrix;
        logic [3:0]  alpha;
        logic        load_luma;
        logic        load_chroma;
    } cfg_t;

    state_t             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    cfg_t               cfg_q, cfg_d;
    logic               done_q, done_d;

    logic [31:0]        field_val;
    logic [5:0]         field_bits;
    logic [15:0]        hdr_size;
    logic [QM_BITS-1:0] qm_word;
    logic [5:0]         entry;
    logic [31:0]        src;
    logic               to_tail;
    logic               unused_qm_hi;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cfg_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cfg_q   <= cfg_d;
            done_q  <= done_d;
        end
    end

    assign hdr_size = 16'd20 + (cfg_q.load_luma ? 16'd64 : 16'd0)
                             + (cfg_q.load_chroma ? 16'd64 : 16'd0);

    always_comb begin
        field_val  = '0;
        field_bits = '0;
        case (idx_q)
            6'd0:  begin field_val = 32'd0;                     field_bits = 6'd32; end
            6'd1:  begin field_val = 32'h69637066;              field_bits = 6'd32; end
            6'd2:  begin field_val = 32'(hdr_size);             field_bits = 6'd16; end
            6'd3:  begin field_val = 32'd0;                     field_bits = 6'd8;  end
            6'd4:  begin field_val = 32'd0;                     field_bits = 6'd8;  end
            6'd5:  begin field_val = ENCODER_ID;                field_bits = 6'd32; end
            6'd6:  begin field_val = 32'(cfg_q.horizontal);     field_bits = 6'd16; end
            6'd7:  begin field_val = 32'(cfg_q.vertical);       field_bits = 6'd16; end
            6'd8:  begin field_val = 32'(cfg_q.chroma_format);  field_bits = 6'd2;  end
            6'd9:  begin field_val = 32'd0;                     field_bits = 6'd2;  end
            6'd10: begin field_val = 32'(cfg_q.interlace_mode); field_bits = 6'd2;  end
            6'd11: begin field_val = 32'd0;                     field_bits = 6'd2;  end
            6'd12: begin field_val = 32'(cfg_q.aspect);         field_bits = 6'd4;  end
            6'd13: begin field_val = 32'(cfg_q.frame_rate);     field_bits = 6'd4;  end
            6'd14: begin field_val = 32'(cfg_q.primaries);      field_bits = 6'd8;  end
            6'd15: begin field_val = 32'(cfg_q.transfer);       field_bits = 6'd8;  end
            6'd16: begin field_val = 32'(cfg_q.matrix);         field_bits = 6'd8;  end
            6'd17: begin field_val = 32'd4;                     field_bits = 6'd4;  end
            6'd18: begin field_val = 32'(cfg_q.alpha);          field_bits = 6'd4;  end
            6'd19: begin field_val = 32'd0;                     field_bits = 6'd8;  end
            6'd20: begin field_val = 32'd0;                     field_bits = 6'd6;  end
            6'd21: begin field_val = 32'(cfg_q.load_luma);      field_bits = 6'd1;  end
            6'd22: begin field_val = 32'(cfg_q.load_chroma);    field_bits = 6'd1;  end
            default: ;
        endcase
    end

    // Entry k of the beat lands k fields below the top, so [0][0] leads.
    always_comb begin
        qm_word = '0;
        entry   = '0;
        src     = '0;
        for (int unsigned k = 0; k < QM_PER_BEAT; k++) begin
            entry = 6'(idx_q * 6'(QM_PER_BEAT) + 6'(k));
            src   = (state_q == S_CHROMA_QM) ? C_QMAT[entry[5:3]][entry[2:0]]
                                             : Y_QMAT[entry[5:3]][entry[2:0]];
            qm_word[(QM_PER_BEAT-1-k)*QM_ENTRY_BITS +: QM_ENTRY_BITS] =
                src[QM_ENTRY_BITS-1:0];
        end
    end

    // Entry bits above QM_ENTRY_BITS are deliberately discarded.
    always_comb begin
        unused_qm_hi = 1'b0;
        for (int unsigned r = 0; r < 8; r++) begin
            for (int unsigned c = 0; c < 8; c++) begin
                unused_qm_hi = unused_qm_hi ^ (^Y_QMAT[r][c]) ^ (^C_QMAT[r][c]);
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        cfg_d             = cfg_q;
        done_d            = 1'b0;
        to_tail           = 1'b0;
        bus.output_enable = 1'b0;
        bus.val           = '0;
        bus.size_of_bit   = '0;
        bus.flush_bit     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // The done cycle is still idle; a start seen there is dropped.
                if (start && !done_q) begin
                    cfg_d.horizontal     = horizontal;
                    cfg_d.vertical       = vertical;
                    cfg_d.chroma_format  = chroma_format;
                    cfg_d.interlace_mode = interlace_mode;
                    cfg_d.aspect         = aspect_ratio_information;
                    cfg_d.frame_rate     = frame_rate_code;
                    cfg_d.primaries      = color_primaries;
                    cfg_d.transfer       = transfer_characteristic;
                    cfg_d.matrix         = matrix_coefficients;
                    cfg_d.alpha          = alpha_channel_type;
                    cfg_d.load_luma      = load_luma;
                    cfg_d.load_chroma    = load_chroma;
                    state_d              = S_FIELDS;
                    idx_d                = '0;
                end
            end
            S_FIELDS: begin
                bus.output_enable = 1'b1;
                bus.val           = VAL_W'(field_val);
                bus.size_of_bit   = VAL_W'(field_bits);
                if (bus.out_ready) begin
                    if (idx_q == FIELD_LAST) begin
                        idx_d = '0;
                        if (cfg_q.load_luma)        state_d = S_LUMA_QM;
                        else if (cfg_q.load_chroma) state_d = S_CHROMA_QM;
                        else                        to_tail = 1'b1;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_LUMA_QM, S_CHROMA_QM: begin
                bus.output_enable = 1'b1;
                bus.val           = VAL_W'(qm_word);
                bus.size_of_bit   = VAL_W'(QM_BITS);
                if (bus.out_ready) begin
                    if (idx_q == QM_LAST) begin
                        idx_d = '0;
                        if (state_q == S_LUMA_QM && cfg_q.load_chroma) state_d = S_CHROMA_QM;
                        else                                           to_tail = 1'b1;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
`ifdef FRAME_HEADER_FLUSH_EN
            S_FLUSH: begin
                bus.output_enable = 1'b1;
                bus.flush_bit     = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (to_tail) begin
`ifdef FRAME_HEADER_FLUSH_EN
            state_d = S_FLUSH;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_frame_header_gen.sv
module tb_frame_header_gen;
`ifdef FRAME_HEADER_FLUSH_EN
    localparam int FL = 1;
`else
    localparam int FL = 0;
`endif

    typedef struct packed {
        logic [63:0] v;
        logic [63:0] s;
        logic        f;
    } beat_t;

    logic        clock;
    logic        reset_n;
    logic        start, start8;
    logic [15:0] hor, ver;
    logic [1:0]  cf, im;
    logic [3:0]  ar, frc, act;
    logic [7:0]  cp, tc, mc;
    logic        ll, lc;
    logic [31:0] y_qm [8][8];
    logic [31:0] c_qm [8][8];
    logic        busy, done, busy8, done8;

    int checks   = 0;
    int failures = 0;

    beat_t got[$];
    beat_t exp_q[$];
    int    done_cyc[$];
    int    done_cnt;
    bit    aborted;

    frame_header_gen_if #(.VAL_W(64)) bus  ();
    frame_header_gen_if #(.VAL_W(64)) bus8 ();

    frame_header_gen #(.QM_PER_BEAT(1)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .horizontal(hor), .vertical(ver), .chroma_format(cf), .interlace_mode(im),
        .aspect_ratio_information(ar), .frame_rate_code(frc), .color_primaries(cp),
        .transfer_characteristic(tc), .matrix_coefficients(mc), .alpha_channel_type(act),
        .load_luma(ll), .load_chroma(lc), .Y_QMAT(y_qm), .C_QMAT(c_qm),
        .bus(bus), .busy(busy), .done(done)
    );

    frame_header_gen #(.QM_PER_BEAT(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start8),
        .horizontal(hor), .vertical(ver), .chroma_format(cf), .interlace_mode(im),
        .aspect_ratio_information(ar), .frame_rate_code(frc), .color_primaries(cp),
        .transfer_characteristic(tc), .matrix_coefficients(mc), .alpha_channel_type(act),
        .load_luma(ll), .load_chroma(lc), .Y_QMAT(y_qm), .C_QMAT(c_qm),
        .bus(bus8), .busy(busy8), .done(done8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference header built straight from the field table.
    task automatic build_exp(input int qpb);
        logic [31:0] fv [23];
        int          fb [23];
        logic [63:0] v;
        int          e;
        fv = '{32'd0, 32'h69637066, 32'(20 + 64 * int'(ll) + 64 * int'(lc)), 32'd0, 32'd0,
               32'h4c617663, 32'(hor), 32'(ver), 32'(cf), 32'd0, 32'(im), 32'd0,
               32'(ar), 32'(frc), 32'(cp), 32'(tc), 32'(mc), 32'd4, 32'(act),
               32'd0, 32'd0, 32'(ll), 32'(lc)};
        fb = '{32, 32, 16, 8, 8, 32, 16, 16, 2, 2, 2, 2, 4, 4, 8, 8, 8, 4, 4, 8, 6, 1, 1};
        exp_q.delete();
        for (int i = 0; i < 23; i++) exp_q.push_back('{64'(fv[i]), 64'(fb[i]), 1'b0});
        for (int m = 0; m < 2; m++) begin
            if ((m == 0 && ll) || (m == 1 && lc)) begin
                for (int b = 0; b < 64 / qpb; b++) begin
                    v = '0;
                    for (int k = 0; k < qpb; k++) begin
                        e = b * qpb + k;
                        v = (v << 8) | 64'(m == 0 ? y_qm[e / 8][e % 8][7:0]
                                                  : c_qm[e / 8][e % 8][7:0]);
                    end
                    exp_q.push_back('{v, 64'(qpb * 8), 1'b0});
                end
            end
        end
        if (FL == 1) exp_q.push_back('{64'd0, 64'd0, 1'b1});
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s_b%0d_val", tag, i + 1), got[i].v, exp_q[i].v);
            chk($sformatf("%s_b%0d_size", tag, i + 1), got[i].s, exp_q[i].s);
            chk($sformatf("%s_b%0d_flush", tag, i + 1), 64'(got[i].f), 64'(exp_q[i].f));
        end
    endtask

    task automatic run_hdr(input bit use8, input bit rnd, input bit hold,
                           input int n_hdr, input int abort_at);
        int          cyc;
        bit          stalled, rdy;
        logic        oe, fl, dn, bz, pf;
        logic [63:0] v, s, pv, ps;
        got.delete();
        done_cyc.delete();
        done_cnt = 0;
        aborted  = 0;
        stalled  = 0;
        pv = '0; ps = '0; pf = 1'b0;
        cyc = 0;
        @(posedge clock); #1;
        if (use8) start8 = 1'b1; else start = 1'b1;
        bus.out_ready  = 1'b1;
        bus8.out_ready = 1'b1;
        while (cyc < 1000) begin
            @(posedge clock); #1;
            cyc++;
            if (!hold) begin start = 1'b0; start8 = 1'b0; end
            oe = use8 ? bus8.output_enable : bus.output_enable;
            v  = use8 ? bus8.val : bus.val;
            s  = use8 ? bus8.size_of_bit : bus.size_of_bit;
            fl = use8 ? bus8.flush_bit : bus.flush_bit;
            dn = use8 ? done8 : done;
            bz = use8 ? busy8 : busy;
            if (stalled) begin
                chk("stall_oe", 64'(oe), 64'd1);
                chk("stall_val", v, pv);
                chk("stall_size", s, ps);
                chk("stall_flush", 64'(fl), 64'(pf));
            end
            if (dn) begin
                done_cnt++;
                done_cyc.push_back(cyc);
                chk("done_busy", 64'(bz), 64'd0);
                chk("done_oe", 64'(oe), 64'd0);
                if (done_cnt == n_hdr) begin
                    start = 1'b0; start8 = 1'b0;
                    break;
                end
            end
            if (abort_at > 0 && oe && got.size() == abort_at - 1) begin
                reset_n = 1'b0;
                #1;
                chk("abort_oe", 64'(bus.output_enable), 64'd0);
                chk("abort_val", bus.val, 64'd0);
                chk("abort_size", bus.size_of_bit, 64'd0);
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_done", 64'(done), 64'd0);
                #1 reset_n = 1'b1;
                aborted = 1;
                break;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready  = rdy;
            bus8.out_ready = rdy;
            if (oe && rdy) got.push_back('{v, s, fl});
            stalled = oe && !rdy;
            pv = v; ps = s; pf = fl;
        end
        bus.out_ready  = 1'b1;
        bus8.out_ready = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; start8 = 1'b0;
        bus.out_ready = 1'b0; bus8.out_ready = 1'b0;
        hor = 16'd1920; ver = 16'd1080; cf = 2'd2; im = 2'd1;
        ar = 4'd3; frc = 4'd5; cp = 8'h09; tc = 8'h10; mc = 8'h0b; act = 4'd1;
        ll = 1'b0; lc = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin y_qm[r][c] = '0; c_qm[r][c] = '0; end

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_oe", 64'(bus.output_enable), 64'd0);
        chk("rst_val", bus.val, 64'd0);
        chk("rst_size", bus.size_of_bit, 64'd0);
        chk("rst_flush", 64'(bus.flush_bit), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        #2 reset_n = 1'b1;

        // T1: no matrices, 1920x1080
        run_hdr(0, 0, 0, 1, 0);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_done_cyc", 64'(done_cyc[0]), 64'(24 + FL));
        chk("t1_b1_val", got[0].v, 64'd0);
        chk("t1_b2_val", got[1].v, 64'h69637066);
        chk("t1_b3_val", got[2].v, 64'h14);
        chk("t1_b3_size", got[2].s, 64'd16);
        chk("t1_b6_val", got[5].v, 64'h4c617663);
        chk("t1_b7_val", got[6].v, 64'd1920);
        chk("t1_b7_size", got[6].s, 64'd16);
        chk("t1_b8_val", got[7].v, 64'd1080);
        chk("t1_b8_size", got[7].s, 64'd16);
        build_exp(1);
        cmp_all("t1");

        // T2: both matrices, one entry per beat; upper entry bits must be dropped
        ll = 1'b1; lc = 1'b1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin y_qm[r][c] = 32'hABCD0004; c_qm[r][c] = 32'h00000105; end
        run_hdr(0, 0, 0, 1, 0);
        chk("t2_count", 64'(got.size()), 64'(151 + FL));
        chk("t2_hdr_size", got[2].v, 64'h94);
        chk("t2_b24_val", got[23].v, 64'd4);
        chk("t2_b24_size", got[23].s, 64'd8);
        chk("t2_b87_val", got[86].v, 64'd4);
        chk("t2_b88_val", got[87].v, 64'd5);
        chk("t2_b151_val", got[150].v, 64'd5);
        chk("t2_b151_size", got[150].s, 64'd8);
        build_exp(1);
        cmp_all("t2");

        // T3: eight entries per beat, chroma only
        ll = 1'b0; lc = 1'b1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) c_qm[r][c] = 32'(r * 8 + c + 1);
        run_hdr(1, 0, 0, 1, 0);
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);
        chk("t3_count", 64'(got.size()), 64'(31 + FL));
        chk("t3_hdr_size", got[2].v, 64'd84);
        chk("t3_qm1_val", got[23].v, 64'h0102030405060708);
        chk("t3_qm1_size", got[23].s, 64'd64);
        build_exp(8);
        cmp_all("t3");

        // T4: random backpressure over a full header
        ll = 1'b1; lc = 1'b1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                y_qm[r][c] = 32'h5500_0000 | 32'(r * 8 + c + 8'h40);
                c_qm[r][c] = 32'(8'hff - 8'(r * 8 + c));
            end
        run_hdr(0, 1, 0, 1, 0);
        chk("t4_done_cnt", 64'(done_cnt), 64'd1);
        build_exp(1);
        cmp_all("t4");

        // T5: reset during beat 40, then a clean restart
        run_hdr(0, 0, 0, 0, 40);
        chk("t5_aborted", 64'(aborted), 64'd1);
        chk("t5_abort_done_cnt", 64'(done_cnt), 64'd0);
        chk("t5_abort_beats", 64'(got.size()), 64'd39);
        repeat (2) @(posedge clock);
        #1;
        chk("t5_idle_busy", 64'(busy), 64'd0);
        run_hdr(0, 0, 0, 1, 0);
        chk("t5_done_cnt", 64'(done_cnt), 64'd1);
        cmp_all("t5");

        // T6: start held high across two headers
        ll = 1'b0; lc = 1'b0;
        build_exp(1);
        exp_q = {exp_q, exp_q};
        run_hdr(0, 0, 1, 2, 0);
        chk("t6_done_cnt", 64'(done_cnt), 64'd2);
        chk("t6_done1_cyc", 64'(done_cyc[0]), 64'(24 + FL));
        chk("t6_done2_cyc", 64'(done_cyc[1]), 64'(49 + 2 * FL));
        cmp_all("t6");
        repeat (3) @(posedge clock);
        #1;
        chk("t6_after_busy", 64'(busy), 64'd0);
        chk("t6_after_oe", 64'(bus.output_enable), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
